// File: rtl/pc_unit.sv
// pc_unit: program-counter unit for the fetch stage.
//
// Holds the fetch PC and chooses the next one each cycle from a trap entry,
// an EX-stage branch/jump redirect (with alignment check), a fetch stall, a
// return prediction from a small circular return-address stack (RAS), or a
// plain sequential step.
//
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   stall                          hold PC (hazard unit)
//   redirect_valid, redirect_addr  taken branch/jump target from EX
//   trap_valid, trap_vector        exception/interrupt entry
//   call_push, call_ret_addr       decoded call: push return address
//   ret_pred                       decoded return: predict target from RAS
//   pc_out, pc_valid               current fetch address and its validity
//   flush                          one-cycle pulse: squash IF/ID
//   misaligned_err/_addr           one-cycle pulse + captured bad target
//   ras_empty, ras_full            RAS occupancy flags
module pc_unit #(
  parameter int XLEN         = 32,
  parameter int INC          = 4,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int RAS_DEPTH    = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_addr,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_vector,
  input  logic            call_push,
  input  logic [XLEN-1:0] call_ret_addr,
  input  logic            ret_pred,
  output logic [XLEN-1:0] pc_out,
  output logic            pc_valid,
  output logic            flush,
  output logic            misaligned_err,
  output logic [XLEN-1:0] misaligned_addr,
  output logic            ras_empty,
  output logic            ras_full
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {BOOT, RUN} state_t;

  state_t          state_reg, state_next;
  logic [XLEN-1:0] pc_reg, pc_next;
  logic            flush_reg, flush_next;
  logic            mis_err_reg, mis_err_next;
  logic [XLEN-1:0] mis_addr_reg, mis_addr_next;
  logic [PW-1:0]   ptr_reg, ptr_next;
  logic [CW-1:0]   count_reg, count_next;

  // Small RAS: read asynchronously because a predicted return must load
  // the top entry into the PC on the same edge it is requested.
  logic [XLEN-1:0] ras_mem [RAS_DEPTH];
  logic            ras_we;
  logic [PW-1:0]   ras_waddr;
  logic [XLEN-1:0] ras_top;
  logic            misaligned;

  assign ras_top = ras_mem[ptr_reg];

  generate
    if (INC == 4) begin : g_align_byte
      assign misaligned = |redirect_addr[1:0];
    end else begin : g_align_word
      assign misaligned = 1'b0;
    end
  endgenerate

  assign pc_out          = pc_reg;
  assign pc_valid        = (state_reg == RUN);
  assign flush           = flush_reg;
  assign misaligned_err  = mis_err_reg;
  assign misaligned_addr = mis_addr_reg;
  assign ras_empty       = (count_reg == '0);
  assign ras_full        = (count_reg == CW'(RAS_DEPTH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= BOOT;
      pc_reg       <= RESET_VECTOR;
      flush_reg    <= 1'b0;
      mis_err_reg  <= 1'b0;
      mis_addr_reg <= '0;
      ptr_reg      <= '0;
      count_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      pc_reg       <= pc_next;
      flush_reg    <= flush_next;
      mis_err_reg  <= mis_err_next;
      mis_addr_reg <= mis_addr_next;
      ptr_reg      <= ptr_next;
      count_reg    <= count_next;
    end
  end

  // Entry contents need no reset; write enable is low throughout BOOT.
  always_ff @(posedge clk) begin
    if (ras_we) begin
      ras_mem[ras_waddr] <= call_ret_addr;
    end
  end

  always_comb begin
    state_next    = state_reg;
    pc_next       = pc_reg;
    flush_next    = 1'b0;
    mis_err_next  = 1'b0;
    mis_addr_next = mis_addr_reg;
    ptr_next      = ptr_reg;
    count_next    = count_reg;
    ras_we        = 1'b0;
    ras_waddr     = ptr_reg;

    if (state_reg == BOOT) begin
      // First edge out of reset only validates the reset vector.
      state_next = RUN;
    end else if (trap_valid) begin
      pc_next    = trap_vector;
      flush_next = 1'b1;
    end else if (redirect_valid) begin
      if (misaligned) begin
        mis_err_next  = 1'b1;
        mis_addr_next = redirect_addr;
      end else begin
        pc_next    = redirect_addr;
        flush_next = 1'b1;
      end
    end else if (!stall) begin
      if (ret_pred && !ras_empty) begin
        pc_next = ras_top;
        if (call_push) begin
          // Pop and push in one cycle: replace the top in place.
          ras_we = 1'b1;
        end else begin
          ptr_next   = ptr_reg - 1'b1;
          count_next = count_reg - 1'b1;
        end
      end else begin
        pc_next = pc_reg + XLEN'(INC);
        if (call_push) begin
          // Pointer wraps, so a push when full overwrites the oldest entry.
          ras_we    = 1'b1;
          ras_waddr = ptr_reg + 1'b1;
          ptr_next  = ptr_reg + 1'b1;
          if (!ras_full) begin
            count_next = count_reg + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_addr;
  logic        trap_valid;
  logic [31:0] trap_vector;
  logic        call_push;
  logic [31:0] call_ret_addr;
  logic        ret_pred;
  logic [31:0] pc_out;
  logic        pc_valid;
  logic        flush;
  logic        misaligned_err;
  logic [31:0] misaligned_addr;
  logic        ras_empty;
  logic        ras_full;

  int errors = 0;
  int checks = 0;

  pc_unit #(
    .XLEN(32), .INC(4), .RESET_VECTOR(32'h100), .RAS_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .trap_valid(trap_valid), .trap_vector(trap_vector),
    .call_push(call_push), .call_ret_addr(call_ret_addr),
    .ret_pred(ret_pred), .pc_out(pc_out), .pc_valid(pc_valid),
    .flush(flush), .misaligned_err(misaligned_err),
    .misaligned_addr(misaligned_addr),
    .ras_empty(ras_empty), .ras_full(ras_full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one clock; sample 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    stall = 0; redirect_valid = 0; redirect_addr = 0;
    trap_valid = 0; trap_vector = 0; call_push = 0;
    call_ret_addr = 0; ret_pred = 0;
  endtask

  initial begin
    rst = 1;
    clear_inputs();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pc", pc_out, 32'h100);
    chk("rst_valid", {31'b0, pc_valid}, 0);
    chk("rst_flush", {31'b0, flush}, 0);
    chk("rst_mis", {31'b0, misaligned_err}, 0);
    chk("rst_mis_addr", misaligned_addr, 0);
    chk("rst_empty", {31'b0, ras_empty}, 1);
    chk("rst_full", {31'b0, ras_full}, 0);
    rst = 0;

    // Boot edge, then sequential.
    step(); chk("boot_pc", pc_out, 32'h100); chk("boot_valid", {31'b0, pc_valid}, 1);
    step(); chk("seq1", pc_out, 32'h104);
    step(); chk("seq2", pc_out, 32'h108);
    step(); chk("seq3", pc_out, 32'h10C);

    // Redirect to 0x10, then stall, then redirect under stall.
    redirect_valid = 1; redirect_addr = 32'h10;
    step(); chk("redir10_pc", pc_out, 32'h10); chk("redir10_flush", {31'b0, flush}, 1);
    redirect_valid = 0; stall = 1;
    step(); chk("stall1_pc", pc_out, 32'h10); chk("stall1_flush", {31'b0, flush}, 0);
    step(); chk("stall2_pc", pc_out, 32'h10);
    redirect_valid = 1; redirect_addr = 32'h200;
    step(); chk("redir_stall_pc", pc_out, 32'h200); chk("redir_stall_flush", {31'b0, flush}, 1);
    clear_inputs();
    step(); chk("after_redir_pc", pc_out, 32'h204); chk("flush_one_cycle", {31'b0, flush}, 0);

    // Trap beats redirect; misaligned redirect rejected.
    trap_valid = 1; trap_vector = 32'h80; redirect_valid = 1; redirect_addr = 32'h300;
    step(); chk("trap_pc", pc_out, 32'h80); chk("trap_flush", {31'b0, flush}, 1);
    trap_valid = 0; redirect_addr = 32'h302;
    step();
    chk("mis_pc_hold", pc_out, 32'h80);
    chk("mis_err", {31'b0, misaligned_err}, 1);
    chk("mis_addr", misaligned_addr, 32'h302);
    chk("mis_flush", {31'b0, flush}, 0);
    clear_inputs();
    step();
    chk("mis_pulse_end", {31'b0, misaligned_err}, 0);
    chk("mis_addr_kept", misaligned_addr, 32'h302);
    chk("post_mis_pc", pc_out, 32'h84);

    // RAS fill and wrap.
    call_push = 1;
    call_ret_addr = 32'hA0; step(); chk("push1_pc", pc_out, 32'h88); chk("push1_empty", {31'b0, ras_empty}, 0);
    call_ret_addr = 32'hB0; step(); chk("push2_pc", pc_out, 32'h8C);
    call_ret_addr = 32'hC0; step(); chk("push3_full", {31'b0, ras_full}, 0);
    call_ret_addr = 32'hD0; step(); chk("push4_full", {31'b0, ras_full}, 1);
    call_ret_addr = 32'hE0; step(); chk("push5_full", {31'b0, ras_full}, 1); chk("push5_pc", pc_out, 32'h98);
    call_push = 0; ret_pred = 1;
    step(); chk("pop1", pc_out, 32'hE0); chk("pop1_full", {31'b0, ras_full}, 0);
    step(); chk("pop2", pc_out, 32'hD0);
    step(); chk("pop3", pc_out, 32'hC0);
    step(); chk("pop4", pc_out, 32'hB0); chk("pop4_empty", {31'b0, ras_empty}, 1);
    step(); chk("pop_empty_seq", pc_out, 32'hB4);

    // Push ignored under stall.
    ret_pred = 0; stall = 1; call_push = 1; call_ret_addr = 32'h55;
    step(); chk("stall_push_pc", pc_out, 32'hB4); chk("stall_push_empty", {31'b0, ras_empty}, 1);
    stall = 0; call_ret_addr = 32'h40;
    step(); chk("push40_pc", pc_out, 32'hB8);

    // Simultaneous push/pop replaces top.
    call_ret_addr = 32'h60; ret_pred = 1;
    step(); chk("pushpop_pc", pc_out, 32'h40); chk("pushpop_empty", {31'b0, ras_empty}, 0);
    call_push = 0;
    step(); chk("pop60_pc", pc_out, 32'h60); chk("pop60_empty", {31'b0, ras_empty}, 1);
    clear_inputs();

    // PC wrap-around.
    redirect_valid = 1; redirect_addr = 32'hFFFF_FFFC;
    step(); chk("wrap_pre", pc_out, 32'hFFFF_FFFC);
    redirect_valid = 0;
    step(); chk("wrap_zero", pc_out, 32'h0);
    call_push = 1; call_ret_addr = 32'h123;
    step(); chk("wrap_push_pc", pc_out, 32'h4); chk("wrap_push_empty", {31'b0, ras_empty}, 0);
    clear_inputs();

    // Asynchronous reset mid-cycle.
    #3 rst = 1;
    #1;
    chk("arst_pc", pc_out, 32'h100);
    chk("arst_valid", {31'b0, pc_valid}, 0);
    chk("arst_empty", {31'b0, ras_empty}, 1);
    step();
    rst = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised program-counter unit for the pipelined core's fetch stage; successor to the simple jump/increment PC.
- Adds configurable width and step, reset vector, fetch stall, and a trap entry with fixed priority.
- Adds a branch/jump redirect with alignment checking, a one-cycle flush pulse, and a small circular return-address stack (RAS) for call/return prediction.
- Sits in IF; drives instruction-memory address and receives redirects from EX and traps from the CSR/exception logic.

Parameters:
- XLEN, 32, PC and address width in bits.
- INC, 4, sequential step added per advance. Legal values: 1 (word-indexed memory) or 4 (byte-addressed).
- RESET_VECTOR, 0, PC value loaded on reset.
- RAS_DEPTH, 4, return-address-stack entries. Power of two, minimum 2.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- stall  in  1  hold PC; from hazard unit.
- redirect_valid  in  1  taken branch/jump resolved in EX.
- redirect_addr  in  XLEN  branch/jump target.
- trap_valid  in  1  exception/interrupt entry request.
- trap_vector  in  XLEN  trap handler address.
- call_push  in  1  decoded call; push return address.
- call_ret_addr  in  XLEN  return address to push.
- ret_pred  in  1  decoded return; predict target from RAS.
- pc_out  out  XLEN  current fetch address.
- pc_valid  out  1  pc_out is a valid fetch address.
- flush  out  1  one-cycle pulse: squash IF/ID.
- misaligned_err  out  1  one-cycle pulse: rejected misaligned redirect.
- misaligned_addr  out  XLEN  captured offending target.
- ras_empty  out  1  RAS holds no entries.
- ras_full  out  1  RAS holds RAS_DEPTH entries.

Behaviour:
- Reset values while rst is high:
  - pc_out = RESET_VECTOR; pc_valid = 0; flush = 0; misaligned_err = 0; misaligned_addr = 0.
  - RAS count = 0, so ras_empty = 1 and ras_full = 0. RAS pointer = 0. Entry contents are don't-care.
- FSM has two states, BOOT and RUN:
  - Reset forces BOOT.
  - The first clk edge with rst low moves to RUN and sets pc_valid = 1. pc_out stays RESET_VECTOR on that edge.
  - In RUN, pc_valid = 1 permanently.
  - rst asserted at any time returns immediately and asynchronously to BOOT with reset values.
  - All inputs are ignored in BOOT.
- Next-PC priority in RUN, evaluated each edge (highest first):
  1. trap_valid: pc <= trap_vector; flush = 1 next cycle. No alignment check on the vector.
  2. redirect_valid with aligned target: pc <= redirect_addr; flush = 1 next cycle.
  3. redirect_valid with misaligned target: pc holds; misaligned_err = 1 next cycle; misaligned_addr <= redirect_addr; flush = 0.
  4. stall: pc holds.
  5. ret_pred with RAS not empty: pc <= RAS top; entry popped.
  6. Otherwise: pc <= pc + INC, wrapping modulo 2^XLEN.
- Alignment rule:
  - INC=4: misaligned when redirect_addr[1:0] != 0.
  - INC=1: never misaligned.
- flush and misaligned_err are registered, one cycle wide. Back-to-back events give back-to-back pulses.
- A trap or redirect overrides stall in the same cycle.
- RAS rules:
  - RAS operations take effect only when none of trap_valid, redirect_valid or stall is asserted. Otherwise call_push and ret_pred are ignored entirely, including the pop.
  - Push: write call_ret_addr at pointer+1 and advance the pointer. count increments, saturating at RAS_DEPTH.
  - Push when full: overwrites the oldest entry (circular wrap); count stays at RAS_DEPTH.
  - Pop (ret_pred, not empty): pc takes the top entry; pointer decrements (wraps); count decrements.
  - ret_pred when empty: ignored; PC advances sequentially.
  - call_push and ret_pred together, not empty: pc <= old top, and the top entry is replaced by call_ret_addr. Pointer and count unchanged.
  - call_push and ret_pred together, empty: plain push; PC sequential.
  - The RAS is not rolled back on flush or trap. Mispredicted returns are corrected by a later EX redirect.
- ras_empty and ras_full are combinational from count.
- Latency: every PC update becomes visible on pc_out one cycle after the controlling input is sampled.

Test Plan:
- Reset and boot: hold rst 3 cycles, release, run 4 edges with INC=4, RESET_VECTOR=0x100 -> pc_valid 0 until the first edge, then pc_out = 0x100, 0x104, 0x108, 0x10C.
- Stall vs redirect: stall=1 for 2 cycles at pc_out=0x10 -> pc_out holds 0x10. Then redirect_valid=1, redirect_addr=0x200 with stall still high -> pc_out=0x200 and flush=1 for exactly one cycle.
- Priority and alignment: trap_valid with trap_vector=0x80 and redirect 0x300 in the same cycle -> pc_out=0x80. Then redirect 0x302 -> pc holds, misaligned_err pulses, misaligned_addr=0x302, flush=0.
- RAS wrap (RAS_DEPTH=4): push 0xA0, 0xB0, 0xC0, 0xD0, 0xE0 -> ras_full=1 after the 4th push. Then 4 ret_pred -> pc_out = 0xE0, 0xD0, 0xC0, 0xB0 and ras_empty=1. 5th ret_pred -> pc = previous + 4.
- Simultaneous push/pop with top=0x40: call_push(0x60) and ret_pred together -> pc_out=0x40, count unchanged. Next ret_pred -> pc_out=0x60.
- Wrap and reset mid-run: XLEN=32, pc=0xFFFFFFFC, advance -> pc_out=0x00000000. Assert rst asynchronously mid-cycle -> pc_out=RESET_VECTOR, pc_valid=0 and ras_empty=1 immediately.
